// File: rtl/base_hps_pio_pkg.sv
// rtl/base_hps_pio_pkg.sv - register map shared by the LED PIO and its users
package base_hps_pio_pkg;

    localparam int unsigned BUS_WIDTH = 32;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_BLINK_MASK   = 3'd2;
    localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd3;
    localparam logic [2:0] ADDR_OUTSET       = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;
    localparam logic [2:0] ADDR_STATUS       = 3'd6;

endpackage

// File: rtl/base_hps_led_pio_blink.sv
// rtl/base_hps_led_pio_blink.sv - half-period counter producing the blink phase
module base_hps_led_pio_blink #(
    parameter int unsigned DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] period,
    input  logic                 clear,
    output logic                 phase
);

    logic [DIV_WIDTH-1:0] r_count;
    logic                 r_phase;
    logic                 w_wrap;

    // Wrap when the counter reaches the last cycle of the half-period.
    assign w_wrap = (period != '0) && (r_count == (period - DIV_WIDTH'(1)));
    assign phase  = r_phase;

    // Counter and phase; a period write (clear) beats a coincident wrap.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
            r_phase <= 1'b0;
        end else if (period == '0) begin
            r_count <= '0;
        end else if (w_wrap) begin
            r_count <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_count <= r_count + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/base_hps_led_pio.sv
// rtl/base_hps_led_pio.sv - Avalon-MM LED PIO with set/clear and masked blinking
module base_hps_led_pio
    import base_hps_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 0,
    parameter int unsigned DIV_WIDTH   = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [2:0]           address,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic [WIDTH-1:0]     out_port
);

    localparam logic [WIDTH-1:0] L_RESET_DATA = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0]     r_data;
    logic [WIDTH-1:0]     r_mask;
    logic [DIV_WIDTH-1:0] r_period;
    logic [31:0]          r_readdata;
    logic [WIDTH-1:0]     r_out_port;

    logic                 w_wr;
    logic                 w_period_wr;
    logic                 w_phase;
    logic [WIDTH-1:0]     w_wd_data;
    logic [DIV_WIDTH-1:0] w_wd_period;
    logic [BUS_WIDTH-1:0] w_rd_mux;
    logic                 w_unused_wdata;

    assign w_wr           = chipselect && !write_n;
    assign w_period_wr    = w_wr && (address == ADDR_BLINK_PERIOD);
    assign w_wd_data      = writedata[WIDTH-1:0];
    assign w_wd_period    = writedata[DIV_WIDTH-1:0];
    assign w_unused_wdata = ^writedata;

    assign readdata = r_readdata;
    assign out_port = r_out_port;

    base_hps_led_pio_blink #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_blink (
        .clk    (clk),
        .reset  (reset),
        .period (r_period),
        .clear  (w_period_wr),
        .phase  (w_phase)
    );

    // Bus writes; OUTSET/OUTCLEAR modify the DATA value held before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data   <= L_RESET_DATA;
            r_mask   <= '0;
            r_period <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:         r_data   <= w_wd_data;
                ADDR_BLINK_MASK:   r_mask   <= w_wd_data;
                ADDR_BLINK_PERIOD: r_period <= w_wd_period;
                ADDR_OUTSET:       r_data   <= r_data | w_wd_data;
                ADDR_OUTCLEAR:     r_data   <= r_data & ~w_wd_data;
                default:           ;
            endcase
        end
    end

    // Read mux for the presented address, zero-extended; write-only and reserved read 0.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:         w_rd_mux[WIDTH-1:0]     = r_data;
            ADDR_BLINK_MASK:   w_rd_mux[WIDTH-1:0]     = r_mask;
            ADDR_BLINK_PERIOD: w_rd_mux[DIV_WIDTH-1:0] = r_period;
            ADDR_STATUS:       w_rd_mux[0]             = w_phase;
            default:           ;
        endcase
    end

    // Registered read data, loaded every cycle independent of chipselect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    // Registered pin drive: DATA with masked bits inverted while phase is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_port <= L_RESET_DATA;
        end else begin
            r_out_port <= r_data ^ (r_mask & {WIDTH{w_phase}});
        end
    end

endmodule

// File: tb/tb_base_hps_led_pio.sv
// tb/tb_base_hps_led_pio.sv - self-checking bench for base_hps_led_pio
module tb_base_hps_led_pio;

    localparam logic [7:0] RV = 8'h5A;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write_n;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int errors = 0;
    int checks = 0;

    // Reference state: register contents and the edge index of the last blink restart.
    longint      n;
    longint      t0;
    logic [7:0]  md;
    logic [7:0]  mm;
    int unsigned mp;

    always #5 clk = ~clk;

    base_hps_led_pio #(
        .WIDTH       (8),
        .RESET_VALUE (32'h5A),
        .DIV_WIDTH   (24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write_n    (write_n),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    // Phase after edge n: number of whole half-periods elapsed since restart, mod 2.
    function automatic logic mphase();
        if (mp == 0) return 1'b0;
        return 1'(((n - t0) / longint'(mp)) % 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic wn,
                        input logic [2:0] a, input logic [31:0] d);
        logic        p;
        logic [31:0] erd;
        logic [7:0]  eout;
        reset      = r;
        chipselect = c;
        write_n    = wn;
        address    = a;
        writedata  = d;
        p   = mphase();
        erd = 32'd0;
        if (!r) begin
            case (a)
                3'd0:    erd = {24'd0, md};
                3'd2:    erd = {24'd0, mm};
                3'd3:    erd = mp;
                3'd6:    erd = {31'd0, p};
                default: erd = 32'd0;
            endcase
        end
        eout = r ? RV : (md ^ (mm & {8{p}}));
        if (r) begin
            md = RV; mm = 8'd0; mp = 0; t0 = n + 1;
        end else if (c && !wn) begin
            case (a)
                3'd0: md = d[7:0];
                3'd2: mm = d[7:0];
                3'd3: begin mp = {8'd0, d[23:0]}; t0 = n + 1; end
                3'd4: md = md | d[7:0];
                3'd5: md = md & ~d[7:0];
                default: ;
            endcase
        end
        @(posedge clk);
        n++;
        #1;
        chk("model_readdata", readdata, erd);
        chk("model_out_port", {24'd0, out_port}, {24'd0, eout});
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b0, 1'b0, 1'b1, a, 32'd0);
    endtask

    initial begin
        logic [31:0] exp27;
        logic        prev;
        longint      last;
        logic        rr, rc, rwn;
        logic [2:0]  ra;
        logic [31:0] rdat;

        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        md = RV; mm = 8'd0; mp = 0; n = 0; t0 = 0;
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_out_port", {24'd0, out_port}, {24'd0, RV});

        rd(3'd0);
        chk("read_after_reset", readdata, {24'd0, RV});

        exp27 = (32'hA5 | 32'h0F) & ~32'h81;
        wr(3'd0, 32'hA5);
        wr(3'd4, 32'h0F);
        wr(3'd5, 32'h81);
        rd(3'd0);
        chk("setclr_data", readdata, exp27);
        chk("setclr_out_port", {24'd0, out_port}, exp27);

        step(1'b0, 1'b0, 1'b0, 3'd0, 32'hFF);
        step(1'b0, 1'b1, 1'b1, 3'd0, 32'hFF);
        wr(3'd1, 32'hFF);
        wr(3'd7, 32'hFF);
        rd(3'd0);
        chk("ignored_writes_data", readdata, exp27);
        rd(3'd1);
        chk("reserved1_read", readdata, 32'd0);
        rd(3'd7);
        chk("reserved7_read", readdata, 32'd0);
        rd(3'd4);
        chk("outset_read", readdata, 32'd0);
        wr(3'd0, 32'hFFFFFF00);
        rd(3'd0);
        chk("upper_bits_ignored", readdata, 32'd0);

        wr(3'd2, 32'h01);
        wr(3'd3, 32'h3);
        prev = out_port[0];
        last = -1;
        for (int i = 0; i < 16; i++) begin
            rd(3'd6);
            chk("blink_steady_bits", {25'd0, out_port[7:1]}, 32'd0);
            if (out_port[0] !== prev) begin
                if (last >= 0) chk("blink_interval", 32'(n - last), 32'd3);
                last = n;
                prev = out_port[0];
            end
        end

        wr(3'd3, 32'h1);
        rd(3'd0);
        prev = out_port[0];
        for (int i = 0; i < 4; i++) begin
            rd(3'd0);
            chk("period1_toggle", {31'd0, out_port[0]}, {31'd0, ~prev});
            prev = out_port[0];
        end

        wr(3'd3, 32'h3);
        for (int i = 0; i < 3 && (((n + 1 - t0) % longint'(mp)) != 0); i++) rd(3'd0);
        wr(3'd3, 32'h3);
        for (int i = 0; i < 4; i++) begin
            rd(3'd6);
            chk("wrap_write_phase", readdata, (i == 3) ? 32'd1 : 32'd0);
        end

        wr(3'd3, 32'h0);
        repeat (3) rd(3'd6);
        chk("period0_hold", readdata, 32'd0);

        for (int i = 0; i < 400; i++) begin
            rr   = ($urandom_range(0, 63) == 0);
            rc   = ($urandom_range(0, 3) != 0);
            rwn  = ($urandom_range(0, 2) == 0);
            ra   = 3'($urandom_range(0, 7));
            rdat = $urandom;
            if (ra == 3'd3) rdat = (rdat & 32'hFF000000) | $urandom_range(0, 5);
            step(rr, rc, rwn, ra, rdat);
        end

        wr(3'd2, 32'hFF);
        wr(3'd0, 32'h00);
        wr(3'd3, 32'h2);
        repeat (5) rd(3'd0);
        step(1'b1, 1'b1, 1'b0, 3'd0, 32'h33);
        chk("reset_mid_blink_out", {24'd0, out_port}, {24'd0, RV});
        chk("reset_mid_blink_rd", readdata, 32'd0);
        for (int i = 0; i < 10; i++) begin
            rd(3'd6);
            chk("no_toggle_after_reset", readdata, 32'd0);
            chk("out_after_reset", {24'd0, out_port}, {24'd0, RV});
        end
        rd(3'd2);
        chk("mask_after_reset", readdata, 32'd0);
        rd(3'd3);
        chk("period_after_reset", readdata, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
